lcd_window_gen: RTL and testbench

// Parametrised LCD data-enable/window generator. Sits after the scandoubler/OSD on the LCD path.

---
 rtl/lcd_window_gen.sv | 166 ++++++++++++++++
 tb/tb_lcd_window_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_window_gen.sv
// LCD data-enable/window generator: derives lcd_de, signed pixel/line positions
// and a frame-length lock flag from scandoubled hs_n/vs_n.
module lcd_window_gen #(
  parameter int CW          = 12,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int H_START0    = -104,
  parameter int H_START1    = -104,
  parameter int H_START2    = -69,
  parameter int V_START0    = -34,
  parameter int V_START1    = -94,
  parameter int V_START2    = 0
) (
  input  logic          clk_pixel,
  input  logic          por,
  input  logic          hs_n,
  input  logic          vs_n,
  input  logic [1:0]    vmode,
  input  logic          trim_we,
  input  logic [7:0]    h_trim,
  input  logic [7:0]    v_trim,
  output logic          lcd_de,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          frame_start,
  output logic          locked
);

  localparam logic signed [CW-1:0] POS_MAX = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [CW-1:0] H_ACT_S = CW'(H_ACTIVE);
  localparam logic signed [CW-1:0] V_ACT_S = CW'(V_ACTIVE);
  localparam logic [4:0]           LOCK_W  = 5'(LOCK_FRAMES);

  logic                 last_hs_n_q, last_hs_n_d;
  logic                 last_vs_n_q, last_vs_n_d;
  logic [1:0]           mode_q, mode_d;
  logic [7:0]           h_trim_q, h_trim_d;
  logic [7:0]           v_trim_q, v_trim_d;
  logic signed [CW-1:0] hpos_q, hpos_d;
  logic signed [CW-1:0] vpos_q, vpos_d;
  logic [CW-1:0]        lines_q, lines_d;
  logic [CW-1:0]        prev_lines_q, prev_lines_d;
  logic [3:0]           stable_q, stable_d;
  logic                 locked_q, locked_d;
  logic                 frame_start_q, frame_start_d;

  logic                 hs_rise, vs_rise, mode_change;
  logic [1:0]           vmode_n;
  logic signed [CW-1:0] h_start_sel, v_start_sel, h_load, v_load;
  logic [CW-1:0]        lines_inc;
  logic [4:0]           stable_p1;

  assign hs_rise     = hs_n & ~last_hs_n_q;
  assign vs_rise     = hs_rise & vs_n & ~last_vs_n_q;
  assign vmode_n     = (vmode == 2'd3) ? 2'd2 : vmode;
  assign mode_change = hs_rise & (vmode_n != mode_q);
  assign lines_inc   = (lines_q == '1) ? lines_q : lines_q + CW'(1);
  assign stable_p1   = {1'b0, stable_q} + 5'd1;

  // Start offsets follow the mode registered on the previous line start.
  always_comb begin
    h_start_sel = CW'(H_START2);
    v_start_sel = CW'(V_START2);
    case (mode_q)
      2'd0: begin
        h_start_sel = CW'(H_START0);
        v_start_sel = CW'(V_START0);
      end
      2'd1: begin
        h_start_sel = CW'(H_START1);
        v_start_sel = CW'(V_START1);
      end
      default: ;
    endcase
  end

  assign h_load = h_start_sel + CW'($signed(h_trim_q));
  assign v_load = v_start_sel + CW'($signed(v_trim_q));

  always_comb begin
    last_hs_n_d   = hs_n;
    last_vs_n_d   = last_vs_n_q;
    mode_d        = mode_q;
    h_trim_d      = h_trim_q;
    v_trim_d      = v_trim_q;
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    lines_d       = lines_q;
    prev_lines_d  = prev_lines_q;
    stable_d      = stable_q;
    locked_d      = locked_q;
    frame_start_d = vs_rise;

    if (trim_we) begin
      h_trim_d = h_trim;
      v_trim_d = v_trim;
    end

    if (hs_rise) begin
      last_vs_n_d = vs_n;
      mode_d      = vmode_n;
      hpos_d      = h_load;
      lines_d     = lines_inc;
      if (vs_rise) begin
        vpos_d       = v_load;
        prev_lines_d = lines_inc;
        lines_d      = CW'(1);
        if (lines_inc == prev_lines_q) begin
          stable_d = (stable_p1 >= LOCK_W) ? LOCK_W[3:0] : stable_p1[3:0];
          locked_d = (stable_p1 >= LOCK_W);
        end else begin
          stable_d = 4'd0;
          locked_d = 1'b0;
        end
      end else begin
        vpos_d = (vpos_q == POS_MAX) ? vpos_q : vpos_q + CW'(1);
      end
      // A mode switch wins over an equal-length compare on the same edge.
      if (mode_change) begin
        stable_d = 4'd0;
        locked_d = 1'b0;
      end
    end else begin
      hpos_d = (hpos_q == POS_MAX) ? hpos_q : hpos_q + CW'(1);
    end
  end

  always_ff @(posedge clk_pixel or posedge por) begin
    if (por) begin
      last_hs_n_q   <= 1'b1;
      last_vs_n_q   <= 1'b1;
      mode_q        <= 2'd0;
      h_trim_q      <= 8'd0;
      v_trim_q      <= 8'd0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      lines_q       <= '0;
      prev_lines_q  <= '0;
      stable_q      <= 4'd0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      last_hs_n_q   <= last_hs_n_d;
      last_vs_n_q   <= last_vs_n_d;
      mode_q        <= mode_d;
      h_trim_q      <= h_trim_d;
      v_trim_q      <= v_trim_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      lines_q       <= lines_d;
      prev_lines_q  <= prev_lines_d;
      stable_q      <= stable_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign lcd_de      = locked_q & ~hpos_q[CW-1] & (hpos_q < H_ACT_S)
                                & ~vpos_q[CW-1] & (vpos_q < V_ACT_S);
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_lcd_window_gen.sv
// Bench for lcd_window_gen: scaled-down video timing, a frame-level table,
// randomized frames and hand-written reset/sync-loss sequences.
module tb_lcd_window_gen;

  localparam int CW    = 12;
  localparam int HA    = 48;
  localparam int VA    = 16;
  localparam int LOCKF = 2;
  localparam int HS0   = -12;
  localparam int HS1   = -12;
  localparam int HS2   = -7;
  localparam int VS0   = -4;
  localparam int VS1   = -9;
  localparam int VS2   = 0;
  localparam int LINE  = 80;
  localparam int HSW   = 10;
  localparam int VSW   = 3;
  localparam int PMAX  = 2047;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          por;
  logic          hs_n, vs_n, trim_we;
  logic [1:0]    vmode;
  logic [7:0]    h_trim, v_trim;
  logic          lcd_de, frame_start, locked;
  logic [CW-1:0] hpos, vpos;

  always #5 clk = ~clk;

  lcd_window_gen #(
    .CW(CW), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LOCKF),
    .H_START0(HS0), .H_START1(HS1), .H_START2(HS2),
    .V_START0(VS0), .V_START1(VS1), .V_START2(VS2)
  ) dut (
    .clk_pixel(clk), .por(por), .hs_n(hs_n), .vs_n(vs_n), .vmode(vmode),
    .trim_we(trim_we), .h_trim(h_trim), .v_trim(v_trim), .lcd_de(lcd_de),
    .hpos(hpos), .vpos(vpos), .frame_start(frame_start), .locked(locked)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Positions are "load value + elapsed count", capped at PMAX. Lock is judged
  // from the history of measured frame lengths and the last mode switch.
  int m_hbase, m_hcnt, m_vbase, m_vcnt;
  int m_htrim, m_vtrim, m_mode;
  bit m_last_hs, m_last_vs, m_fs, m_seen_vs;
  int m_rises, m_nvs, m_unlock_at;
  int m_lens[$];

  function automatic int hstart(int m);
    case (m)
      0: return HS0;
      1: return HS1;
      default: return HS2;
    endcase
  endfunction

  function automatic int vstart(int m);
    case (m)
      0: return VS0;
      1: return VS1;
      default: return VS2;
    endcase
  endfunction

  task automatic model_reset();
    m_hbase = 0; m_hcnt = 0; m_vbase = 0; m_vcnt = 0;
    m_htrim = 0; m_vtrim = 0; m_mode = 0;
    m_last_hs = 1'b1; m_last_vs = 1'b1; m_fs = 1'b0; m_seen_vs = 1'b0;
    m_rises = 0; m_nvs = 0; m_unlock_at = 0;
    m_lens.delete();
    m_lens.push_back(0);
  endtask

  function automatic bit model_locked();
    int last;
    if (m_nvs - m_unlock_at < LOCKF) return 1'b0;
    last = m_lens.size() - 1;
    for (int j = 0; j < LOCKF; j++)
      if (m_lens[last-j] != m_lens[last-j-1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int cap(int v);
    return (v > PMAX) ? PMAX : v;
  endfunction

  task automatic model_step();
    bit hr, vr;
    int nm;
    if (por) begin
      model_reset();
      return;
    end
    hr = hs_n && !m_last_hs;
    m_last_hs = hs_n;
    nm = (vmode == 2'd3) ? 2 : int'(vmode);
    m_fs = 1'b0;
    if (hr) begin
      vr = vs_n && !m_last_vs;
      m_last_vs = vs_n;
      m_hbase = hstart(m_mode) + m_htrim;
      m_hcnt = 0;
      m_rises++;
      if (vr) begin
        m_nvs++;
        m_lens.push_back(m_rises + (m_seen_vs ? 1 : 0));
        m_rises = 0;
        m_seen_vs = 1'b1;
        m_vbase = vstart(m_mode) + m_vtrim;
        m_vcnt = 0;
        m_fs = 1'b1;
      end else if (m_vbase + m_vcnt < PMAX) begin
        m_vcnt++;
      end
      if (nm != m_mode) begin
        m_unlock_at = m_nvs;
        m_mode = nm;
      end
    end else if (m_hbase + m_hcnt < PMAX) begin
      m_hcnt++;
    end
    if (trim_we) begin
      m_htrim = int'($signed(h_trim));
      m_vtrim = int'($signed(v_trim));
    end
  endtask

  // ---------------- scoreboard ----------------
  int cur_col, cur_line, first_de_col, first_de_line;
  int frame_de_col[64];

  task automatic check_outputs();
    int eh, ev;
    bit el, ed;
    eh = cap(m_hbase + m_hcnt);
    ev = cap(m_vbase + m_vcnt);
    el = model_locked();
    ed = el && eh >= 0 && eh < HA && ev >= 0 && ev < VA;
    chk("hpos", int'($signed(hpos)), eh);
    chk("vpos", int'($signed(vpos)), ev);
    chk("locked", int'(locked), int'(el));
    chk("lcd_de", int'(lcd_de), int'(ed));
    chk("frame_start", int'(frame_start), int'(m_fs));
    if (lcd_de && first_de_col < 0) first_de_col = cur_col;
    if (lcd_de && first_de_line < 0) first_de_line = cur_line;
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic gen_line(bit vs_low, int trim_col, int ht, int vt);
    first_de_col = -1;
    for (int c = 0; c < LINE; c++) begin
      cur_col = c;
      hs_n    = (c >= HSW);
      vs_n    = !vs_low;
      trim_we = (c == trim_col);
      h_trim  = (c == trim_col) ? 8'(ht) : 8'($urandom);
      v_trim  = (c == trim_col) ? 8'(vt) : 8'($urandom);
      tick();
    end
    trim_we = 1'b0;
  endtask

  task automatic gen_frame(int n, int mode, int trim_line, int trim_col, int ht, int vt);
    vmode = 2'(mode);
    first_de_line = -1;
    for (int l = 0; l < n; l++) begin
      cur_line = l;
      gen_line(l < VSW, (l == trim_line) ? trim_col : -1, ht, vt);
      if (l < 64) frame_de_col[l] = first_de_col;
    end
  endtask

  typedef struct {
    int mode;
    int nlines;
    int trim_line;
    int ht;
    int vt;
    bit exp_locked;
  } fvec_t;

  fvec_t tbl[14];

  initial begin
    // lock, trim, one short frame, then a switch to PAL
    tbl[0]  = '{0, 26, -1, 0, 0, 1'b0};
    tbl[1]  = '{0, 26, -1, 0, 0, 1'b0};
    tbl[2]  = '{0, 26, -1, 0, 0, 1'b0};
    tbl[3]  = '{0, 26, -1, 0, 0, 1'b1};
    tbl[4]  = '{0, 26, 10, 8, -2, 1'b1};
    tbl[5]  = '{0, 25, -1, 0, 0, 1'b1};
    tbl[6]  = '{0, 26, -1, 0, 0, 1'b0};
    tbl[7]  = '{0, 26, -1, 0, 0, 1'b0};
    tbl[8]  = '{0, 26, -1, 0, 0, 1'b0};
    tbl[9]  = '{0, 26, 10, 0, 0, 1'b1};
    tbl[10] = '{1, 30, -1, 0, 0, 1'b0};
    tbl[11] = '{1, 30, -1, 0, 0, 1'b0};
    tbl[12] = '{1, 30, -1, 0, 0, 1'b0};
    tbl[13] = '{1, 30, -1, 0, 0, 1'b1};

    model_reset();
    por = 1'b1; hs_n = 1'b1; vs_n = 1'b1; vmode = 2'd0;
    trim_we = 1'b0; h_trim = 8'd0; v_trim = 8'd0;
    cur_col = 0; cur_line = 0; first_de_col = -1; first_de_line = -1;

    // reset held with toggling syncs
    for (int i = 0; i < 40; i++) begin
      hs_n = 1'($urandom); vs_n = 1'($urandom); vmode = 2'($urandom);
      tick();
    end
    por = 1'b0; hs_n = 1'b1; vs_n = 1'b1; vmode = 2'd0;

    // frame-level table
    for (int i = 0; i < 14; i++) begin
      gen_frame(tbl[i].nlines, tbl[i].mode, tbl[i].trim_line, 50, tbl[i].ht, tbl[i].vt);
      chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].exp_locked));
      if (i == 3) begin
        chk("lock_first_de_line", first_de_line, VSW - VS0);
        chk("lock_de_col", frame_de_col[VSW - VS0], HSW - HS0);
      end
      if (i == 4) begin
        chk("trim_same_line_col", frame_de_col[10], HSW - HS0);
        chk("trim_next_line_col", frame_de_col[11], HSW - HS0 - 8);
        chk("trim_frame_de_line", first_de_line, VSW - VS0);
      end
      if (i == 5) chk("vtrim_next_frame_line", first_de_line, VSW - VS0 + 2);
      if (i == 13) begin
        chk("pal_first_de_line", first_de_line, VSW - VS1);
        chk("pal_de_col", frame_de_col[VSW - VS1], HSW - HS1);
      end
    end

    // randomized frames: length jitter, occasional mode switch, random trims
    for (int f = 0; f < 6; f++) begin
      int mode, n, tl;
      mode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : int'(vmode);
      n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(24, 28)) : 26;
      tl   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 23)) : -1;
      gen_frame(n, mode, tl, int'($urandom_range(0, LINE - 1)),
                int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 6)) - 3);
    end

    // sync loss: hpos must saturate, never wrap into the window
    hs_n = 1'b1; vs_n = 1'b1;
    for (int i = 0; i < 5000; i++) tick();
    chk("sat_hpos", int'($signed(hpos)), PMAX);
    chk("sat_de", int'(lcd_de), 0);

    // asynchronous reset in the middle of a line
    gen_frame(26, 0, -1, 0, 0, 0);
    gen_frame(26, 0, -1, 0, 0, 0);
    hs_n = 1'b1;
    #2 por = 1'b1;
    #1;
    chk("por_hpos", int'($signed(hpos)), 0);
    chk("por_vpos", int'($signed(vpos)), 0);
    chk("por_locked", int'(locked), 0);
    chk("por_de", int'(lcd_de), 0);
    @(negedge clk);
    tick();
    tick();
    por = 1'b0;
    for (int l = 0; l < 5; l++) gen_line(1'b0, -1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      gen_frame(26, 0, -1, 0, 0, 0);
      chk($sformatf("relock%0d", i), int'(locked), (i == 3) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
